// File: rtl/regfile_writeback.sv
// Write-side master for the register file: merges ALU results and in-order
// load responses into one registered write per cycle; tracks pending loads.
// Ports: clk, rst (async active-low); ALU in; load issue/response; decode
// sources; load_full, hazard_stall; rd_address/register_write_en/_data;
// wb_error. Optional WB_BYPASS_EN adds byp_a/b_valid and byp_a/b_data.
module regfile_writeback #(
  parameter int LOAD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        load_issue,
  input  logic [4:0]  load_rd,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        mem_resp_ready,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  output logic        load_full,
  output logic        hazard_stall,
  output logic [4:0]  rd_address,
  output logic        register_write_en,
  output logic [31:0] register_write_data,
  output logic        wb_error
`ifdef WB_BYPASS_EN
  ,
  output logic        byp_a_valid,
  output logic        byp_b_valid,
  output logic [31:0] byp_a_data,
  output logic [31:0] byp_b_data
`endif
);

  localparam int PW = $clog2(LOAD_DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    fifo_q [LOAD_DEPTH];
  logic [4:0]    fifo_d [LOAD_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          hold_valid_q, hold_valid_d;
  logic [31:0]   hold_data_q, hold_data_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic          wb_en_q, wb_en_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          err_q, err_d;

  logic       full;
  logic       sel_hold;
  logic       push;
  logic       accept;
  logic       has_entry;
  logic [4:0] head_rd;

  assign full     = (count_q == CW'(LOAD_DEPTH));
  assign head_rd  = fifo_q[rd_ptr_q];
  assign sel_hold = !alu_valid && hold_valid_q;
  assign push     = load_issue && (!full || sel_hold);

  // The hold register frees up on the same edge it drains, so a new
  // response can be taken without a bubble.
  assign mem_resp_ready = !hold_valid_q || sel_hold;
  assign accept         = mem_resp_valid && mem_resp_ready;

  // The hold entry always owns the FIFO head; a new response needs
  // another pending destination behind it.
  assign has_entry = count_q > {{PW{1'b0}}, hold_valid_q};

  always_comb begin
    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = load_rd;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = sel_hold ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(sel_hold);

    hold_valid_d = hold_valid_q && !sel_hold;
    hold_data_d  = hold_data_q;
    if (accept && has_entry) begin
      hold_valid_d = 1'b1;
      hold_data_d  = mem_resp_data;
    end

    wb_en_d   = 1'b0;
    wb_rd_d   = '0;
    wb_data_d = '0;
    if (alu_valid) begin
      wb_en_d   = (alu_rd != 5'd0);
      wb_rd_d   = alu_rd;
      wb_data_d = alu_data;
    end else if (hold_valid_q) begin
      wb_en_d   = (head_rd != 5'd0);
      wb_rd_d   = head_rd;
      wb_data_d = hold_data_q;
    end

    err_d = err_q
          | (accept && !has_entry)
          | (load_issue && full && !sel_hold);
  end

  always_comb begin
    hazard_stall = 1'b0;
    for (int k = 0; k < LOAD_DEPTH; k++) begin
      if (k < int'(count_q)) begin
        if (fifo_q[rd_ptr_q + PW'(k)] != 5'd0 &&
            (fifo_q[rd_ptr_q + PW'(k)] == dec_rs1 ||
             fifo_q[rd_ptr_q + PW'(k)] == dec_rs2 ||
             fifo_q[rd_ptr_q + PW'(k)] == dec_rd))
          hazard_stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LOAD_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      wb_en_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      wb_en_q      <= wb_en_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      err_q        <= err_d;
    end
  end

  assign load_full           = full;
  assign rd_address          = wb_rd_q;
  assign register_write_en   = wb_en_q;
  assign register_write_data = wb_data_q;
  assign wb_error            = err_q;

`ifdef WB_BYPASS_EN
  // Enable already implies rd != 0.
  assign byp_a_valid = wb_en_q && (wb_rd_q == dec_rs1);
  assign byp_b_valid = wb_en_q && (wb_rd_q == dec_rs2);
  assign byp_a_data  = wb_data_q;
  assign byp_b_data  = wb_data_q;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback.
// Linear stimulus; each comparison is an immediate assertion.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        load_issue = 1'b0;
  logic [4:0]  load_rd = '0;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        mem_resp_ready;
  logic [4:0]  dec_rs1 = '0;
  logic [4:0]  dec_rs2 = '0;
  logic [4:0]  dec_rd = '0;
  logic        load_full;
  logic        hazard_stall;
  logic [4:0]  rd_address;
  logic        register_write_en;
  logic [31:0] register_write_data;
  logic        wb_error;
`ifdef WB_BYPASS_EN
  logic        byp_a_valid, byp_b_valid;
  logic [31:0] byp_a_data, byp_b_data;
`endif

  int checks = 0;
  int failures = 0;

  regfile_writeback #(.LOAD_DEPTH(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .alu_valid           (alu_valid),
    .alu_rd              (alu_rd),
    .alu_data            (alu_data),
    .load_issue          (load_issue),
    .load_rd             (load_rd),
    .mem_resp_valid      (mem_resp_valid),
    .mem_resp_data       (mem_resp_data),
    .mem_resp_ready      (mem_resp_ready),
    .dec_rs1             (dec_rs1),
    .dec_rs2             (dec_rs2),
    .dec_rd              (dec_rd),
    .load_full           (load_full),
    .hazard_stall        (hazard_stall),
    .rd_address          (rd_address),
    .register_write_en   (register_write_en),
    .register_write_data (register_write_data),
    .wb_error            (wb_error)
`ifdef WB_BYPASS_EN
    ,
    .byp_a_valid         (byp_a_valid),
    .byp_b_valid         (byp_b_valid),
    .byp_a_data          (byp_a_data),
    .byp_b_data          (byp_b_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr_chk(input string tag, input logic en,
                        input logic [4:0] rd, input logic [31:0] d);
    chk({tag, "_en"}, 32'(register_write_en), 32'(en));
    if (en) begin
      chk({tag, "_rd"}, 32'(rd_address), 32'(rd));
      chk({tag, "_data"}, register_write_data, d);
    end
  endtask

  initial begin
    // 1: reset with random inputs toggling
    for (int i = 0; i < 6; i++) begin
      alu_valid      = 1'($urandom);
      alu_rd         = 5'($urandom);
      alu_data       = $urandom;
      load_issue     = 1'($urandom);
      load_rd        = 5'($urandom);
      mem_resp_valid = 1'($urandom);
      mem_resp_data  = $urandom;
      tick();
    end
    dec_rs1 = 5'($urandom); dec_rs2 = 5'($urandom); dec_rd = 5'($urandom);
    #2 rst = 1'b0;
    #1;
    chk("rst_rd", 32'(rd_address), 32'd0);
    chk("rst_en", 32'(register_write_en), 32'd0);
    chk("rst_data", register_write_data, 32'd0);
    chk("rst_err", 32'(wb_error), 32'd0);
    chk("rst_full", 32'(load_full), 32'd0);
    chk("rst_hazard", 32'(hazard_stall), 32'd0);
    tick();
    alu_valid = 0; load_issue = 0; mem_resp_valid = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    #1;
    chk("rst_ready", 32'(mem_resp_ready), 32'd1);
    tick();
    rst = 1'b1;
    tick();

    // 2: ALU writes
    alu_valid = 1; alu_rd = 5; alu_data = 25;
    tick();
    wr_chk("alu5", 1'b1, 5'd5, 32'd25);
    alu_rd = 0; alu_data = 9;
    tick();
    wr_chk("alu0", 1'b0, 5'd0, 32'd0);
    alu_valid = 0;
    tick();
    wr_chk("idle", 1'b0, 5'd0, 32'd0);

    // 3: two loads, in-order responses, hazard on x7
    load_issue = 1; load_rd = 3;
    tick();
    load_rd = 7;
    tick();
    load_issue = 0;
    dec_rs1 = 7;
    #1;
    chk("haz7_a", 32'(hazard_stall), 32'd1);
    mem_resp_valid = 1; mem_resp_data = 32'hAA;
    #1;
    chk("ready_empty", 32'(mem_resp_ready), 32'd1);
    tick();
    wr_chk("ld_capture", 1'b0, 5'd0, 32'd0);
    mem_resp_data = 32'hBB;
    #1;
    chk("ready_drain", 32'(mem_resp_ready), 32'd1);
    tick();
    mem_resp_valid = 0;
    wr_chk("ld_x3", 1'b1, 5'd3, 32'hAA);
    chk("haz7_b", 32'(hazard_stall), 32'd1);
    tick();
    wr_chk("ld_x7", 1'b1, 5'd7, 32'hBB);
    chk("haz7_c", 32'(hazard_stall), 32'd0);
    dec_rs1 = 0;

    // 4: ALU contention while hold is valid
    load_issue = 1; load_rd = 9;
    tick();
    load_issue = 0;
    mem_resp_valid = 1; mem_resp_data = 32'h99;
    tick();
    mem_resp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 5'(10 + i); alu_data = 32'(100 + i);
      #1;
      chk("cont_ready", 32'(mem_resp_ready), 32'd0);
      tick();
      wr_chk("cont_alu", 1'b1, 5'(10 + i), 32'(100 + i));
    end
    alu_valid = 0;
    tick();
    wr_chk("cont_hold", 1'b1, 5'd9, 32'h99);
    chk("cont_ready2", 32'(mem_resp_ready), 32'd1);

    // 5: fill scoreboard, push+pop at full, push without pop
    load_issue = 1;
    for (int i = 1; i <= 4; i++) begin
      load_rd = 5'(i);
      tick();
    end
    load_issue = 0;
    #1;
    chk("full4", 32'(load_full), 32'd1);
    dec_rd = 4;
    #1;
    chk("haz_rd4", 32'(hazard_stall), 32'd1);
    dec_rd = 0;
    mem_resp_valid = 1; mem_resp_data = 32'h11;
    tick();
    mem_resp_valid = 0;
    load_issue = 1; load_rd = 5;
    tick();
    wr_chk("full_pop", 1'b1, 5'd1, 32'h11);
    chk("full_err0", 32'(wb_error), 32'd0);
    chk("full_still", 32'(load_full), 32'd1);
    load_rd = 6;
    tick();
    load_issue = 0;
    chk("full_err1", 32'(wb_error), 32'd1);
    chk("full_cnt4", 32'(load_full), 32'd1);
    dec_rs1 = 6;
    #1;
    chk("drop_x6", 32'(hazard_stall), 32'd0);
    dec_rs1 = 5;
    #1;
    chk("keep_x5", 32'(hazard_stall), 32'd1);
    dec_rs1 = 0;

    // 6: error on response with empty FIFO, then reset with loads pending
    rst = 0;
    #1;
    chk("rst2_err", 32'(wb_error), 32'd0);
    chk("rst2_full", 32'(load_full), 32'd0);
    tick();
    rst = 1;
    tick();
    mem_resp_valid = 1; mem_resp_data = 32'h55;
    tick();
    mem_resp_valid = 0;
    chk("orphan_err", 32'(wb_error), 32'd1);
    tick();
    wr_chk("orphan_nowr", 1'b0, 5'd0, 32'd0);
    chk("orphan_ready", 32'(mem_resp_ready), 32'd1);
    rst = 0;
    #1;
    rst = 1;
    tick();
    load_issue = 1; load_rd = 8;
    tick();
    load_rd = 9;
    tick();
    load_issue = 0;
    dec_rs2 = 8;
    #1;
    chk("pend_haz", 32'(hazard_stall), 32'd1);
    #2 rst = 0;
    #1;
    chk("rst3_haz", 32'(hazard_stall), 32'd0);
    chk("rst3_full", 32'(load_full), 32'd0);
    chk("rst3_ready", 32'(mem_resp_ready), 32'd1);
    chk("rst3_err", 32'(wb_error), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
